rr_req_gnt_arbiter: RTL and testbench



---
 rtl/rr_req_gnt_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rr_req_gnt_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_gnt_arbiter.sv
// ---------------------------------------------------------------------------
// rr_req_gnt_arbiter
//
// Round-robin arbiter that shares one resource among N requesters. Each
// requester raises a level req and holds it while it wants the resource. The
// arbiter answers with a registered one-hot gnt that also acts as the
// resource select for the downstream datapath.
//
// Handshake (req/gnt):
//   - A requester raises req[i] and keeps it high until it is done.
//   - gnt[i] rises one cycle after the edge at which req[i] won arbitration.
//   - The grant ends at the first edge where the owner has dropped req, has
//     pulsed rel, or has used up MAX_HOLD granted cycles.
//   - Every grant is followed by exactly one cycle with gnt == 0 before the
//     next owner is selected.
//   - rel from anything other than the current owner is ignored.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   req        [N-1:0] level request per requester
//   rel        [N-1:0] release pulse per requester (owner only)
//   gnt        [N-1:0] registered one-hot (or zero) grant
//   busy       high while any gnt bit is high
//   owner_id   [ID_W-1:0] index of the granted requester, 0 when idle
//   timeout    one-cycle pulse in the first idle cycle after a forced revoke
//   dbg_state  [1:0] current FSM state (0 IDLE, 1 GRANT, 2 RECOVER)
//
// Parameters:
//   N         number of requesters (2..16)
//   MAX_HOLD  granted cycles before a forced revoke; 0 disables the timeout
//   ID_W      width of owner_id
//   CNT_W     width of the hold counter
// ---------------------------------------------------------------------------
module rr_req_gnt_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N),
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    rel,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic [ID_W-1:0] owner_id,
  output logic            timeout,
  output logic [1:0]      dbg_state
);

  // With MAX_HOLD = 0 the nominal counter width collapses to zero bits; keep
  // at least one bit so the counter is always a legal vector.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  localparam logic [CW-1:0]   HOLD_MAX   = CW'(MAX_HOLD);
  // The counter reads 1 in the first granted cycle. When the timeout is
  // disabled it is not needed and simply stays at 0.
  localparam logic [CW-1:0]   HOLD_START = (MAX_HOLD != 0) ? CW'(1) : CW'(0);
  // last = N-1 after reset so that requester 0 is searched first.
  localparam logic [ID_W-1:0] LAST_RST   = ID_W'(N - 1);
  localparam logic [N-1:0]    ONE_HOT0   = N'(1);

  logic [1:0]      state;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] last;
  logic [CW-1:0]   hold_cnt;

  // -------------------------------------------------------------------------
  // Round-robin winner search.
  // Priority order is last+1, last+2, ..., N-1, 0, 1, ..., last. This is done
  // as two ordered passes: first the indices above last, then the indices up
  // to and including last. The first set req bit met wins.
  // -------------------------------------------------------------------------
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [N-1:0]    win_onehot;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i] && (i > int'(last))) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!win_found && req[j] && (j <= int'(last))) begin
        win_found = 1'b1;
        win_id    = ID_W'(j);
      end
    end
  end

  assign win_onehot = ONE_HOT0 << win_id;

  // -------------------------------------------------------------------------
  // Grant termination conditions.
  // gnt is one-hot on the owner while in GRANT, so masking req/rel with gnt
  // picks out the owner's bits without a variable index. A simultaneous
  // req-drop and rel is still a single release, and a release always wins
  // over a timeout on the same edge, so timeout is only reported when the
  // hold limit is the sole reason for ending the grant.
  // -------------------------------------------------------------------------
  logic own_req;
  logic own_rel;
  logic release_ev;
  logic hold_hit;

  assign own_req    = |(req & gnt);
  assign own_rel    = |(rel & gnt);
  assign release_ev = !own_req || own_rel;
  assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);

  // -------------------------------------------------------------------------
  // FSM and registered outputs.
  // IDLE and RECOVER both arbitrate at the next edge; RECOVER exists only to
  // force one dead cycle between consecutive owners, so it is never held for
  // more than one cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      last     <= LAST_RST;
      hold_cnt <= '0;
      gnt      <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_GRANT: begin
          if (release_ev || hold_hit) begin
            state    <= S_RECOVER;
            gnt      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            timeout  <= hold_hit && !release_ev;
          end else if (hold_cnt < HOLD_MAX) begin
            // Saturating: the revoke above fires before the count could wrap.
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: begin
          // S_IDLE, S_RECOVER and the unused encoding all arbitrate.
          if (win_found) begin
            state    <= S_GRANT;
            gnt      <= win_onehot;
            owner    <= win_id;
            last     <= win_id;
            hold_cnt <= HOLD_START;
          end else begin
            state    <= S_IDLE;
            gnt      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = |gnt;
  assign owner_id  = owner;
  assign dbg_state = state;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_req_gnt_arbiter
//
// Two arbiters side by side:
//   u_dut0: N=3, MAX_HOLD=4  (round-robin, timeout, release corner cases)
//   u_dut1: N=4, MAX_HOLD=0  (timeout disabled, long hold)
// A per-instance behavioural model runs on every rising edge, pushes the
// expected {timeout, busy, owner_id, gnt} word, and a monitor pops it on the
// falling edge and compares it with the DUT. Directed tasks add their own
// spot checks on the scenarios of interest.
// ---------------------------------------------------------------------------
module tb_rr_req_gnt_arbiter;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [2:0] req0, rel0, gnt0;
  logic       busy0, to0;
  logic [1:0] id0, st0;

  logic [3:0] req1, rel1, gnt1;
  logic       busy1, to1;
  logic [1:0] id1, st1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Model state, one slot per instance.
  int nn[2] = '{3, 4};
  int mh[2] = '{4, 0};
  int m_owner[2];
  int m_held[2];
  int m_last[2];
  bit m_to[2];

  // -------------------------------------------------------------------------
  // Clock / DUTs
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  rr_req_gnt_arbiter #(.N(3), .MAX_HOLD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .rel(rel0), .gnt(gnt0),
    .busy(busy0), .owner_id(id0), .timeout(to0), .dbg_state(st0)
  );

  rr_req_gnt_arbiter #(.N(4), .MAX_HOLD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .rel(rel1), .gnt(gnt1),
    .busy(busy1), .owner_id(id1), .timeout(to1), .dbg_state(st1)
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  task automatic model_reset(input int u);
    m_owner[u] = -1;
    m_held[u]  = 0;
    m_last[u]  = nn[u] - 1;
    m_to[u]    = 1'b0;
  endtask

  task automatic model_step(input int u, input logic [3:0] r, input logic [3:0] l);
    logic [3:0] rs, ls;
    bit rel_ev, to_ev;
    int idx;
    m_to[u] = 1'b0;
    if (m_owner[u] >= 0) begin
      rs = r >> m_owner[u];
      ls = l >> m_owner[u];
      rel_ev = !rs[0] || ls[0];
      to_ev  = (mh[u] != 0) && (m_held[u] >= mh[u]);
      if (rel_ev || to_ev) begin
        m_to[u]    = !rel_ev;
        m_owner[u] = -1;
        m_held[u]  = 0;
      end else begin
        m_held[u] = m_held[u] + 1;
      end
    end else begin
      for (int k = 1; k <= nn[u]; k++) begin
        idx = (m_last[u] + k) % nn[u];
        rs  = r >> idx;
        if (m_owner[u] < 0 && rs[0]) begin
          m_owner[u] = idx;
          m_last[u]  = idx;
          m_held[u]  = 1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_out(input int u);
    logic [3:0] g;
    logic [1:0] id;
    g  = 4'd0;
    id = 2'd0;
    if (m_owner[u] >= 0) begin
      g  = 4'd1 << m_owner[u];
      id = 2'(m_owner[u]);
    end
    return {m_to[u], (m_owner[u] >= 0), id, g};
  endfunction

  task automatic model_loop0();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset(0);
        exp_q0.delete();
      end else begin
        model_step(0, {1'b0, req0}, {1'b0, rel0});
        exp_q0.push_back(model_out(0));
      end
    end
  endtask

  task automatic model_loop1();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset(1);
        exp_q1.delete();
      end else begin
        model_step(1, req1, rel1);
        exp_q1.push_back(model_out(1));
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard monitor (falling edge)
  // -------------------------------------------------------------------------
  task automatic sb_monitor();
    logic [W-1:0] exp_w, got_w;
    forever begin
      @(negedge clk);
      tests_run++;
      if (!$onehot0(gnt0) || !$onehot0(gnt1)) begin
        tests_failed++;
        $display("FAIL onehot0 t=%0t gnt0=%b gnt1=%b", $time, gnt0, gnt1);
      end
      if (exp_q0.size() > 0) begin
        exp_w = exp_q0.pop_front();
        got_w = {to0, busy0, id0, 1'b0, gnt0};
        tests_run++;
        if (got_w !== exp_w) begin
          tests_failed++;
          $display("FAIL sb_u0 t=%0t got=%b exp=%b", $time, got_w, exp_w);
        end
      end
      if (exp_q1.size() > 0) begin
        exp_w = exp_q1.pop_front();
        got_w = {to1, busy1, id1, gnt1};
        tests_run++;
        if (got_w !== exp_w) begin
          tests_failed++;
          $display("FAIL sb_u1 t=%0t got=%b exp=%b", $time, got_w, exp_w);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0 = '0; rel0 = '0; req1 = '0; rel1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req0 = '0; rel0 = '0; req1 = '0; rel1 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({gnt0, busy0, id0, to0, st0} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_u0 got gnt=%b busy=%b id=%0d to=%b st=%0d exp all 0",
               gnt0, busy0, id0, to0, st0);
    end
    tests_run++;
    if ({gnt1, busy1, id1, to1, st1} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_u1 got gnt=%b busy=%b id=%0d to=%b st=%0d exp all 0",
               gnt1, busy1, id1, to1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); req0 = 3'b001;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b001 || id0 !== 2'd0 || busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant got gnt=%b id=%0d busy=%b exp 001/0/1", gnt0, id0, busy0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (gnt0 !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_hold got gnt=%b exp 001", gnt0);
    end
    @(negedge clk); req0 = 3'b000;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b000 || busy0 !== 1'b0 || to0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drop got gnt=%b busy=%b to=%b exp 000/0/0", gnt0, busy0, to0);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    do_reset();
    @(negedge clk); req0 = 3'b111; rel0 = 3'b000;
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'b001 << (i % 3);
      @(posedge clk); #1;
      tests_run++;
      if (gnt0 !== exp_g || id0 !== 2'(i % 3)) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d] got gnt=%b id=%0d exp %b", i, gnt0, id0, exp_g);
      end
      @(negedge clk); rel0 = 3'b000;
      @(posedge clk); #1;
      @(negedge clk); rel0 = exp_g;
      @(posedge clk); #1;
      tests_run++;
      if (gnt0 !== 3'b000 || to0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_gap[%0d] got gnt=%b to=%b exp 000/0", i, gnt0, to0);
      end
      @(negedge clk); rel0 = 3'b000;
    end
    req0 = 3'b000;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk); req0 = 3'b010;
    @(posedge clk); #1;
    @(negedge clk); req0 = 3'b011;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (gnt0 !== 3'b010 || to0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_hold[%0d] got gnt=%b to=%b exp 010/0", c, gnt0, to0);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b000 || to0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_revoke got gnt=%b to=%b exp 000/1", gnt0, to0);
    end
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b001 || to0 !== 1'b0 || id0 !== 2'd0) begin
      tests_failed++;
      $display("FAIL to_next got gnt=%b to=%b id=%0d exp 001/0/0", gnt0, to0, id0);
    end
    @(negedge clk); req0 = 3'b000;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge clk); req0 = 3'b001;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk); rel0 = 3'b001;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b000 || to0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rel_at_limit got gnt=%b to=%b exp 000/0", gnt0, to0);
    end
    @(negedge clk); rel0 = 3'b000; req0 = 3'b011;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b010 || id0 !== 2'd1) begin
      tests_failed++;
      $display("FAIL rr_after_rel got gnt=%b id=%0d exp 010/1", gnt0, id0);
    end
    @(negedge clk); rel0 = 3'b101;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b010) begin
      tests_failed++;
      $display("FAIL nonowner_rel got gnt=%b exp 010", gnt0);
    end
    @(negedge clk); rel0 = 3'b010; req0 = 3'b001;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b000 || to0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rel_and_drop got gnt=%b to=%b exp 000/0", gnt0, to0);
    end
    @(negedge clk); rel0 = 3'b000;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b001) begin
      tests_failed++;
      $display("FAIL grant_after_drop got gnt=%b exp 001", gnt0);
    end
    @(negedge clk); req0 = 3'b000;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); req0 = 3'b100;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b100 || id0 !== 2'd2) begin
      tests_failed++;
      $display("FAIL mid_pre got gnt=%b id=%0d exp 100/2", gnt0, id0);
    end
    #2;
    rst_n = 1'b0;
    req0  = 3'b101;
    #1;
    tests_run++;
    if (gnt0 !== 3'b000 || busy0 !== 1'b0 || id0 !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_async got gnt=%b busy=%b id=%0d exp 000/0/0", gnt0, busy0, id0);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (gnt0 !== 3'b001) begin
      tests_failed++;
      $display("FAIL mid_first got gnt=%b exp 001", gnt0);
    end
    @(negedge clk); req0 = 3'b000;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_timeout();
    do_reset();
    @(negedge clk); req1 = 4'b1000;
    @(posedge clk); #1;
    tests_run++;
    if (gnt1 !== 4'b1000 || id1 !== 2'd3) begin
      tests_failed++;
      $display("FAIL nt_grant got gnt=%b id=%0d exp 1000/3", gnt1, id1);
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (gnt1 !== 4'b1000 || to1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL nt_hold[%0d] got gnt=%b to=%b exp 1000/0", c, gnt1, to1);
      end
    end
    @(negedge clk); req1 = 4'b0000;
    @(posedge clk); #1;
    tests_run++;
    if (gnt1 !== 4'b0000 || to1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL nt_drop got gnt=%b to=%b exp 0000/0", gnt1, to1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) req1 = 4'($urandom_range(0, 15));
      rel0 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rel1 = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
    end
    @(negedge clk);
    req0 = '0; rel0 = '0; req1 = '0; rel1 = '0;
    repeat (3) @(posedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    model_reset(0);
    model_reset(1);
    rst_n = 1'b0;
    req0 = '0; rel0 = '0; req1 = '0; rel1 = '0;
    fork
      model_loop0();
      model_loop1();
      sb_monitor();
      begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_no_timeout();
    test_random();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
